word_to_number: RTL and testbench
=================================

# word_to_number

Sequential, parametrised number parser for the Forth compiler front end. It takes a token buffered by the word collector and converts it into a DATA-bit integer, processing one character per clock. It accepts hex (`0x`), binary (`0b`) and decimal tokens, with an optional leading `-`. It reports a result-valid pulse plus an error code for bad digits, overflow or empty tokens, and its result feeds the literal-push path of the compiler.

## Interface
- `WIDTH`, 32: maximum token length in characters; `i_word` depth.
- `DATA`, 32: result width in bits.
- `WIDTH_BITS`, `$clog2(WIDTH)+1` (localparam): width of `i_len` and the internal index.
- `i_clk`  in  1  clock; all logic on rising edge.
- `i_rst_n`  in  1  synchronous, active-low reset.
- `i_start`  in  1  request to parse; accepted only in IDLE.
- `i_word`  in  8 x WIDTH  token characters, index 0 first; must be held stable while `o_busy`=1.
- `i_len`  in  WIDTH_BITS  token length; latched on accept.
- `o_busy`  out  1  parse in progress.
- `o_valid`  out  1  one-cycle pulse; `o_data`/`o_err`/`o_err_code` are updated in the same cycle.
- `o_data`  out  DATA  parsed value (two's complement when negative); held until the next result.
- `o_err`  out  1  result invalid; equals (`o_err_code` != 0).
- `o_err_code`  out  2  0 = OK, 1 = BAD_DIGIT, 2 = OVERFLOW, 3 = EMPTY.

## Operation
- States: IDLE, SIGN, PREFIX, DIGITS, DONE.
- IDLE:
  - When `i_start`=1, latch `i_len`, clear the accumulator, set idx=0, neg=0, radix=10, assert `o_busy`.
  - If `i_len`=0 or `i_len`>WIDTH, go to DONE with EMPTY. Otherwise go to SIGN.
- SIGN (char idx 0):
  - `-`: set neg=1, idx=1, go to PREFIX. If `i_len`=1, go to DONE with EMPTY instead.
  - Any other character: go to PREFIX without consuming it.
- PREFIX:
  - If char[idx]=`0`, idx+1<len and char[idx+1] is `x`/`X`: radix=16 and idx+=2.
  - If char[idx]=`0`, idx+1<len and char[idx+1] is `b`/`B`: radix=2 and idx+=2.
  - Otherwise radix=10 with no characters consumed.
  - If the prefix consumed the last character, go to DONE with EMPTY. Otherwise go to DIGITS.
  - PREFIX takes exactly one cycle whether or not a prefix is present.
- DIGITS: one character per cycle.
  - Valid digits: `0`-`9` below the radix; for radix 16 also `a`-`f`/`A`-`F`.
  - Any other character, including `-` here, goes to DONE with BAD_DIGIT immediately; remaining characters are not examined.
  - Accumulator update: acc = acc*radix + digit, computed at DATA+4 bits.
  - If any bit at or above DATA is set, latch OVERFLOW and go to DONE.
  - After the character at idx=len-1, go to DONE.
- Magnitude and sign rules:
  - The magnitude is unsigned; the full DATA-bit range is legal, e.g. `0xFFFFFFFF`.
  - When neg=1, `o_data` = (~acc+1) truncated to DATA bits. There is no separate signed-overflow check.
- DONE (one cycle):
  - Drive `o_valid`=1 and `o_busy`=0. Go to IDLE.
  - `o_data` = result when the code is OK, 0 otherwise.
- `i_start` while `o_busy`=1 or in DONE: ignored. There is no queueing.
- Reset values (`i_rst_n`=0 at any edge, including mid-parse): state IDLE; `o_busy`=0, `o_valid`=0, `o_data`=0, `o_err`=0, `o_err_code`=0; accumulator, idx and neg cleared.

## Timing
- The accept edge is E0. SIGN is evaluated at E1 and PREFIX at E2.
- DIGITS consumes one character per edge from E3 onward.
- For n digit characters, DONE is entered at edge E(n+2) and `o_valid` is high for the cycle after E(n+3). Sign and prefix characters do not add cycles beyond SIGN and PREFIX.
- Worst-case latency is WIDTH+3 edges.
- Early termination (EMPTY, BAD_DIGIT, OVERFLOW) enters DONE at the edge after the detecting state. `o_valid` follows one edge later.
- `o_busy` is high from the cycle after E0 through the last DIGITS/PREFIX cycle. It is low in the `o_valid` cycle.
- Back-to-back operation: `i_start` asserted during the `o_valid` cycle is accepted (state is IDLE on the following edge only if `i_start` is sampled in IDLE). The minimum start-to-start spacing is latency+1.

## Test plan
- `0x1aF`, len 5 -> `o_valid` once, `o_data`=0x000001AF, code 0, `o_valid` cycle 3 digits after PREFIX (E6).
- `-42`, len 3 -> `o_data`=0xFFFFFFD6, code 0. Then `0b1011` -> 0x0000000B with start asserted in the `o_valid` cycle of the first token.
- `0x123456789`, len 11 -> code 2 (OVERFLOW) on the 9th digit, `o_data`=0. `0xFFFFFFFF` -> 0xFFFFFFFF, code 0.
- `12g4` -> code 1 at the `g`, `o_valid` two edges after the `g` is seen, remaining characters ignored. `0b102` -> code 1.
- len 0, `-`, `0x`, `-0b`, and len WIDTH+1 -> code 3 each, with `o_data`=0. `0` alone -> 0, code 0.
- Deassert `i_rst_n` for one edge mid-DIGITS of `0xDEADBEEF` -> all outputs 0 and IDLE on the next cycle, no `o_valid`. `i_start` pulses while busy are ignored and the result is unchanged.

Source files
------------

// File: rtl/word_to_number.sv
// Sequential token-to-integer parser: one character per clock, hex (0x), binary (0b)
// or decimal with an optional leading '-', reporting BAD_DIGIT / OVERFLOW / EMPTY.
module word_to_number #(
    parameter int  WIDTH      = 32,
    parameter int  DATA       = 32,
    localparam int WIDTH_BITS = $clog2(WIDTH) + 1
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_start,
    input  logic [WIDTH-1:0][7:0]  i_word,
    input  logic [WIDTH_BITS-1:0]  i_len,
    output logic                   o_busy,
    output logic                   o_valid,
    output logic [DATA-1:0]        o_data,
    output logic                   o_err,
    output logic [1:0]             o_err_code
);

    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] RADIX_DEC = 2'd0;
    localparam logic [1:0] RADIX_HEX = 2'd1;
    localparam logic [1:0] RADIX_BIN = 2'd2;

    localparam logic [1:0] ERR_OK    = 2'd0;
    localparam logic [1:0] ERR_DIGIT = 2'd1;
    localparam logic [1:0] ERR_OVF   = 2'd2;
    localparam logic [1:0] ERR_EMPTY = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SIGN   = 3'd1,
        S_PREFIX = 3'd2,
        S_DIGITS = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    // Digit value of an ASCII character; 31 marks "not a digit in any radix".
    function automatic logic [4:0] digit_val(input logic [7:0] c);
        logic [7:0] t;
        if (c >= 8'h30 && c <= 8'h39) begin
            t = c - 8'h30;
        end else if (c >= 8'h61 && c <= 8'h66) begin
            t = c - 8'h57;
        end else if (c >= 8'h41 && c <= 8'h46) begin
            t = c - 8'h37;
        end else begin
            t = 8'd31;
        end
        return t[4:0];
    endfunction

    state_t                state_q, state_d;
    logic [WIDTH_BITS-1:0] len_q, len_d;
    logic [WIDTH_BITS-1:0] idx_q, idx_d;
    logic [DATA-1:0]       acc_q, acc_d;
    logic                  neg_q, neg_d;
    logic [1:0]            radix_q, radix_d;
    logic [1:0]            code_q, code_d;
    logic                  busy_q, busy_d;
    logic                  valid_q, valid_d;
    logic [DATA-1:0]       data_q, data_d;
    logic                  err_q, err_d;
    logic [1:0]            err_code_q, err_code_d;

    logic [IDX_W-1:0]      sel0_s, sel1_s;
    logic [7:0]            ch_s, ch_nx_s;
    logic [4:0]            dv_s, lim_s;
    logic                  dv_ok_s;
    logic [DATA+3:0]       acc_x_s, prod_s, sum_s;
    logic [WIDTH_BITS-1:0] idx_inc_s, idx_inc2_s;
    logic [DATA-1:0]       result_s;

    // Character fetch, digit decode and the widened multiply-accumulate.
    always_comb begin
        sel0_s     = idx_q[IDX_W-1:0];
        sel1_s     = sel0_s + IDX_W'(1);
        ch_s       = i_word[sel0_s];
        ch_nx_s    = i_word[sel1_s];
        dv_s       = digit_val(ch_s);
        idx_inc_s  = idx_q + WIDTH_BITS'(1);
        idx_inc2_s = idx_q + WIDTH_BITS'(2);
        acc_x_s    = {4'b0000, acc_q};
        case (radix_q)
            RADIX_HEX: begin lim_s = 5'd16; prod_s = acc_x_s << 4;                    end
            RADIX_BIN: begin lim_s = 5'd2;  prod_s = acc_x_s << 1;                    end
            default:   begin lim_s = 5'd10; prod_s = (acc_x_s << 3) + (acc_x_s << 1); end
        endcase
        dv_ok_s  = (dv_s < lim_s);
        sum_s    = prod_s + {{(DATA-1){1'b0}}, dv_s};
        result_s = neg_q ? (~acc_q + {{(DATA-1){1'b0}}, 1'b1}) : acc_q;
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q    <= S_IDLE;
            len_q      <= '0;
            idx_q      <= '0;
            acc_q      <= '0;
            neg_q      <= 1'b0;
            radix_q    <= RADIX_DEC;
            code_q     <= ERR_OK;
            busy_q     <= 1'b0;
            valid_q    <= 1'b0;
            data_q     <= '0;
            err_q      <= 1'b0;
            err_code_q <= ERR_OK;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            idx_q      <= idx_d;
            acc_q      <= acc_d;
            neg_q      <= neg_d;
            radix_q    <= radix_d;
            code_q     <= code_d;
            busy_q     <= busy_d;
            valid_q    <= valid_d;
            data_q     <= data_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
        end
    end

    // Next-state and parse-progress logic.
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        idx_d   = idx_q;
        acc_d   = acc_q;
        neg_d   = neg_q;
        radix_d = radix_q;
        code_d  = code_q;
        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    len_d   = i_len;
                    idx_d   = '0;
                    acc_d   = '0;
                    neg_d   = 1'b0;
                    radix_d = RADIX_DEC;
                    if (i_len == {WIDTH_BITS{1'b0}} || i_len > WIDTH_BITS'(WIDTH)) begin
                        code_d  = ERR_EMPTY;
                        state_d = S_DONE;
                    end else begin
                        code_d  = ERR_OK;
                        state_d = S_SIGN;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_SIGN: begin
                if (ch_s == 8'h2D) begin
                    neg_d = 1'b1;
                    idx_d = idx_inc_s;
                    if (len_q == WIDTH_BITS'(1)) begin
                        code_d  = ERR_EMPTY;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_PREFIX;
                    end
                end else begin
                    state_d = S_PREFIX;
                end
            end
            S_PREFIX: begin
                // A prefix needs both its characters inside the token.
                if (ch_s == 8'h30 && idx_inc_s < len_q &&
                    (ch_nx_s == 8'h78 || ch_nx_s == 8'h58 || ch_nx_s == 8'h62 || ch_nx_s == 8'h42)) begin
                    radix_d = (ch_nx_s == 8'h78 || ch_nx_s == 8'h58) ? RADIX_HEX : RADIX_BIN;
                    idx_d   = idx_inc2_s;
                    if (idx_inc2_s == len_q) begin
                        code_d  = ERR_EMPTY;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_DIGITS;
                    end
                end else begin
                    radix_d = RADIX_DEC;
                    state_d = S_DIGITS;
                end
            end
            S_DIGITS: begin
                if (!dv_ok_s) begin
                    code_d  = ERR_DIGIT;
                    state_d = S_DONE;
                end else if (sum_s[DATA+3:DATA] != 4'b0000) begin
                    code_d  = ERR_OVF;
                    state_d = S_DONE;
                end else begin
                    acc_d = sum_s[DATA-1:0];
                    idx_d = idx_inc_s;
                    if (idx_inc_s == len_q) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_DIGITS;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Registered outputs: busy tracks the next state, results land as DONE retires.
    always_comb begin
        busy_d     = (state_d == S_SIGN) || (state_d == S_PREFIX) || (state_d == S_DIGITS);
        valid_d    = (state_q == S_DONE);
        data_d     = data_q;
        err_d      = err_q;
        err_code_d = err_code_q;
        if (state_q == S_DONE) begin
            err_code_d = code_q;
            err_d      = (code_q != ERR_OK);
            data_d     = (code_q == ERR_OK) ? result_s : {DATA{1'b0}};
        end else begin
            data_d     = data_q;
        end
    end

    assign o_busy     = busy_q;
    assign o_valid    = valid_q;
    assign o_data     = data_q;
    assign o_err      = err_q;
    assign o_err_code = err_code_q;

endmodule

// File: tb/tb_word_to_number.sv
// Directed self-checking bench for word_to_number: latency, value and error code per token.
module tb_word_to_number;

    localparam int WIDTH = 32;
    localparam int DATA  = 32;
    localparam int WB    = $clog2(WIDTH) + 1;

    logic                  clk = 1'b0;
    logic                  i_rst_n;
    logic                  i_start;
    logic [WIDTH-1:0][7:0] i_word;
    logic [WB-1:0]         i_len;
    logic                  o_busy;
    logic                  o_valid;
    logic [DATA-1:0]       o_data;
    logic                  o_err;
    logic [1:0]            o_err_code;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    word_to_number #(.WIDTH(WIDTH), .DATA(DATA)) dut (
        .i_clk      (clk),
        .i_rst_n    (i_rst_n),
        .i_start    (i_start),
        .i_word     (i_word),
        .i_len      (i_len),
        .o_busy     (o_busy),
        .o_valid    (o_valid),
        .o_data     (o_data),
        .o_err      (o_err),
        .o_err_code (o_err_code)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic launch(input string s, input int len);
        i_word = '0;
        for (int i = 0; i < s.len() && i < WIDTH; i++) begin
            i_word[i] = s[i];
        end
        i_len   = WB'(len);
        i_start = 1'b1;
    endtask

    // Consumes edge E0 (the accept edge) and waits for the result pulse.
    task automatic await_result(input string tag, input int lat, input logic [31:0] ed,
                                input logic [1:0] ec, input logic eb, input bit poke);
        int cnt;
        bit seen;
        @(posedge clk); #1;
        i_start = poke && (lat > 1);
        chk({tag, " busy"}, {31'd0, o_busy}, {31'd0, eb});
        chk({tag, " valid@E0"}, {31'd0, o_valid}, 32'd0);
        cnt  = 0;
        seen = 1'b0;
        while (!seen && cnt < 64) begin
            @(posedge clk); #1;
            cnt++;
            i_start = poke && (cnt < lat - 1);
            if (o_valid) seen = 1'b1;
        end
        i_start = 1'b0;
        chk({tag, " latency"}, seen ? cnt : 32'hFFFF_FFFF, lat);
        chk({tag, " data"}, o_data, ed);
        chk({tag, " code"}, {30'd0, o_err_code}, {30'd0, ec});
        chk({tag, " err"}, {31'd0, o_err}, {31'd0, (ec != 2'd0)});
    endtask

    task automatic check_idle(input string tag);
        @(posedge clk); #1;
        chk({tag, " pulse end"}, {31'd0, o_valid}, 32'd0);
        chk({tag, " idle busy"}, {31'd0, o_busy}, 32'd0);
    endtask

    initial begin
        int vc;
        i_rst_n = 1'b0;
        i_start = 1'b0;
        i_word  = '0;
        i_len   = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst busy", {31'd0, o_busy}, 32'd0);
        chk("rst valid", {31'd0, o_valid}, 32'd0);
        chk("rst data", o_data, 32'd0);
        chk("rst code", {30'd0, o_err_code}, 32'd0);
        chk("rst err", {31'd0, o_err}, 32'd0);
        i_rst_n = 1'b1;
        @(posedge clk); #1;

        launch("0x1aF", 5);
        await_result("hex1af", 6, 32'h0000_01AF, 2'd0, 1'b1, 1'b0);
        check_idle("hex1af");

        launch("-42", 3);
        await_result("neg42", 5, 32'hFFFF_FFD6, 2'd0, 1'b1, 1'b0);
        launch("0b1011", 6);
        await_result("b2b bin", 7, 32'h0000_000B, 2'd0, 1'b1, 1'b0);
        check_idle("b2b bin");

        launch("0x123456789", 11);
        await_result("hex ovf", 12, 32'h0000_0000, 2'd2, 1'b1, 1'b0);
        check_idle("hex ovf");

        launch("0xFFFFFFFF", 10);
        await_result("hex max", 11, 32'hFFFF_FFFF, 2'd0, 1'b1, 1'b0);
        check_idle("hex max");

        // Reset pulse while the digits of 0xDEADBEEF are being consumed.
        launch("0xDEADBEEF", 10);
        @(posedge clk); #1;
        i_start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        i_rst_n = 1'b0;
        @(posedge clk); #1;
        i_rst_n = 1'b1;
        chk("midrst busy", {31'd0, o_busy}, 32'd0);
        chk("midrst valid", {31'd0, o_valid}, 32'd0);
        chk("midrst data", o_data, 32'd0);
        chk("midrst code", {30'd0, o_err_code}, 32'd0);
        chk("midrst err", {31'd0, o_err}, 32'd0);
        vc = 0;
        repeat (15) begin
            @(posedge clk); #1;
            if (o_valid || o_busy) vc++;
        end
        chk("midrst quiet", vc, 32'd0);

        launch("12g4", 4);
        await_result("bad g", 6, 32'h0000_0000, 2'd1, 1'b1, 1'b0);
        check_idle("bad g");

        launch("0b102", 5);
        await_result("bad bin", 6, 32'h0000_0000, 2'd1, 1'b1, 1'b0);
        check_idle("bad bin");

        launch("4294967295", 10);
        await_result("dec max", 13, 32'hFFFF_FFFF, 2'd0, 1'b1, 1'b0);
        check_idle("dec max");

        launch("", 0);
        await_result("len0", 1, 32'h0000_0000, 2'd3, 1'b0, 1'b0);
        check_idle("len0");

        launch("4294967296", 10);
        await_result("dec ovf", 13, 32'h0000_0000, 2'd2, 1'b1, 1'b0);
        check_idle("dec ovf");

        launch("-", 1);
        await_result("minus", 2, 32'h0000_0000, 2'd3, 1'b1, 1'b0);
        check_idle("minus");

        launch("0x", 2);
        await_result("0x only", 3, 32'h0000_0000, 2'd3, 1'b1, 1'b0);
        check_idle("0x only");

        launch("-0b", 3);
        await_result("-0b only", 3, 32'h0000_0000, 2'd3, 1'b1, 1'b0);
        check_idle("-0b only");

        launch("111111111111111111111111111111111", WIDTH + 1);
        await_result("too long", 1, 32'h0000_0000, 2'd3, 1'b0, 1'b0);
        check_idle("too long");

        launch("0", 1);
        await_result("zero", 4, 32'h0000_0000, 2'd0, 1'b1, 1'b0);
        check_idle("zero");

        // Extra start pulses during the parse must not disturb it.
        launch("0x1aF", 5);
        await_result("poke", 6, 32'h0000_01AF, 2'd0, 1'b1, 1'b1);
        check_idle("poke");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
